// File: rtl/bsg_manycore_vcache_wh_to_mem_pkg.sv
// Shared types for the vcache DMA wormhole-to-memory endpoint: FSM state encoding.
package bsg_manycore_vcache_wh_to_mem_pkg;

    typedef enum logic [2:0] {
        e_wh_mem_idle,
        e_wh_mem_addr,
        e_wh_mem_wr,
        e_wh_mem_rhdr,
        e_wh_mem_rdata
    } wh_mem_state_e;

endpackage

// File: rtl/bsg_manycore_vcache_wh_to_mem_beat_ctr.sv
// Beat counter plus beat address generator (base + count * beat bytes, wrapping).
// Latency: count updates one cycle after up_i; address is combinational from count and base.
// Backpressure: none; the caller only pulses up_i on an accepted beat.
module bsg_manycore_vcache_wh_mem_beat_ctr #(
    parameter int cnt_width_p  = 3,
    parameter int addr_width_p = 32,
    parameter int beat_bytes_p = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    up_i,
    input  logic [addr_width_p-1:0] base_i,
    output logic [cnt_width_p-1:0]  cnt_o,
    output logic [addr_width_p-1:0] addr_o
);

    logic [cnt_width_p-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (up_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign addr_o = base_i + addr_width_p'(cnt_q) * addr_width_p'(beat_bytes_p);

endmodule

// File: rtl/bsg_manycore_vcache_wh_to_mem.sv
// Edge-of-array vcache DMA wormhole endpoint: one packet at a time into word requests on a valid/ready memory port.
// Latency: one beat per cycle when unstalled; read data is forwarded to the link combinationally (no buffering).
// Backpressure: write beats follow mem_ready_and_i; read data is held at memory until the link is ready. Stats under BSG_MANYCORE_VCACHE_WH_MEM_STATS_EN.
module bsg_manycore_vcache_wh_to_mem
    import bsg_manycore_vcache_wh_to_mem_pkg::*;
#(
    parameter int wh_flit_width_p         = 32,
    parameter int wh_cord_width_p         = 4,
    parameter int wh_len_width_p          = 4,
    parameter int wh_cid_width_p          = 2,
    parameter int vcache_addr_width_p     = 32,
    parameter int vcache_dma_data_width_p = 32,
    parameter int dma_burst_len_p         = 4,
    parameter int mem_addr_width_p        = 32
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [wh_flit_width_p+1:0]         wh_link_sif_i,
    output logic [wh_flit_width_p+1:0]         wh_link_sif_o,
    output logic                               mem_v_o,
    output logic                               mem_w_o,
    output logic [mem_addr_width_p-1:0]        mem_addr_o,
    output logic [vcache_dma_data_width_p-1:0] mem_data_o,
    input  logic                               mem_ready_and_i,
    input  logic                               mem_data_v_i,
    input  logic [vcache_dma_data_width_p-1:0] mem_data_i,
    output logic                               mem_data_yumi_o,
    output logic [31:0]                        stat_rd_o,
    output logic [31:0]                        stat_wr_o
);

    localparam int beat_bytes_lp = vcache_dma_data_width_p / 8;
    localparam int blk_off_lp    = $clog2(dma_burst_len_p * beat_bytes_lp);
    localparam int cnt_width_lp  = $clog2(dma_burst_len_p + 1);
    localparam int hdr_width_lp  = 2 * wh_cord_width_p + wh_len_width_p + 2 * wh_cid_width_p + 1;

    localparam logic [cnt_width_lp-1:0] burst_lp = cnt_width_lp'(dma_burst_len_p);
    localparam logic [cnt_width_lp-1:0] last_lp  = cnt_width_lp'(dma_burst_len_p - 1);
    localparam logic [vcache_addr_width_p-1:0] align_mask_lp =
        {vcache_addr_width_p{1'b1}} << blk_off_lp;

    typedef struct packed {
        logic                       write_not_read;
        logic [wh_cid_width_p-1:0]  src_cid;
        logic [wh_cord_width_p-1:0] src_cord;
        logic [wh_cid_width_p-1:0]  cid;
        logic [wh_len_width_p-1:0]  len;
        logic [wh_cord_width_p-1:0] cord;
    } bsg_cache_wh_header_flit_s;

    // Link bundle layout: {v, ready_and_rev, data}.
    logic                       in_v, out_rdy;
    logic [wh_flit_width_p-1:0] in_data;
    logic                       link_v, link_rdy;
    logic [wh_flit_width_p-1:0] link_data;

    assign in_v    = wh_link_sif_i[wh_flit_width_p+1];
    assign out_rdy = wh_link_sif_i[wh_flit_width_p];
    assign in_data = wh_link_sif_i[wh_flit_width_p-1:0];
    assign wh_link_sif_o = {link_v & ~reset_i, link_rdy & ~reset_i, link_data};

    bsg_cache_wh_header_flit_s hdr_in, resp_hdr;
    assign hdr_in = in_data[hdr_width_lp-1:0];

    logic unused_hdr_fields;
    assign unused_hdr_fields = ^{hdr_in.cord, hdr_in.len, hdr_in.cid};

    wh_mem_state_e state_q, state_d;
    logic [wh_cord_width_p-1:0]  src_cord_q;
    logic [wh_cid_width_p-1:0]   src_cid_q;
    logic                        wnr_q;
    logic [mem_addr_width_p-1:0] base_q;

    logic mem_v, yumi, latch_hdr, latch_base, ctr_clear, req_up, resp_up, rd_done, wr_done;
    logic [cnt_width_lp-1:0]     req_cnt, resp_cnt;
    logic [mem_addr_width_p-1:0] req_addr, unused_resp_addr;

    bsg_manycore_vcache_wh_mem_beat_ctr #(
        .cnt_width_p (cnt_width_lp),
        .addr_width_p(mem_addr_width_p),
        .beat_bytes_p(beat_bytes_lp)
    ) req_ctr (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(ctr_clear),
        .up_i   (req_up),
        .base_i (base_q),
        .cnt_o  (req_cnt),
        .addr_o (req_addr)
    );

    bsg_manycore_vcache_wh_mem_beat_ctr #(
        .cnt_width_p (cnt_width_lp),
        .addr_width_p(mem_addr_width_p),
        .beat_bytes_p(beat_bytes_lp)
    ) resp_ctr (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(ctr_clear),
        .up_i   (resp_up),
        .base_i (base_q),
        .cnt_o  (resp_cnt),
        .addr_o (unused_resp_addr)
    );

    always_comb begin
        resp_hdr          = '0;
        resp_hdr.cord     = src_cord_q;
        resp_hdr.cid      = src_cid_q;
        resp_hdr.len      = wh_len_width_p'(dma_burst_len_p);
    end

    always_comb begin
        state_d    = state_q;
        link_rdy   = 1'b0;
        link_v     = 1'b0;
        link_data  = '0;
        mem_v      = 1'b0;
        mem_w_o    = 1'b0;
        yumi       = 1'b0;
        latch_hdr  = 1'b0;
        latch_base = 1'b0;
        ctr_clear  = 1'b0;
        req_up     = 1'b0;
        resp_up    = 1'b0;
        rd_done    = 1'b0;
        wr_done    = 1'b0;
        case (state_q)
            e_wh_mem_idle: begin
                link_rdy = 1'b1;
                if (in_v) begin
                    latch_hdr = 1'b1;
                    state_d   = e_wh_mem_addr;
                end
            end
            e_wh_mem_addr: begin
                link_rdy = 1'b1;
                if (in_v) begin
                    latch_base = 1'b1;
                    ctr_clear  = 1'b1;
                    state_d    = wnr_q ? e_wh_mem_wr : e_wh_mem_rhdr;
                end
            end
            e_wh_mem_wr: begin
                mem_v    = in_v;
                mem_w_o  = 1'b1;
                link_rdy = mem_ready_and_i;
                if (in_v && mem_ready_and_i) begin
                    req_up = 1'b1;
                    if (req_cnt == last_lp) begin
                        wr_done = 1'b1;
                        state_d = e_wh_mem_idle;
                    end
                end
            end
            e_wh_mem_rhdr: begin
                link_v    = 1'b1;
                link_data = wh_flit_width_p'(resp_hdr);
                if (out_rdy)
                    state_d = e_wh_mem_rdata;
            end
            e_wh_mem_rdata: begin
                // Requests and returning data proceed independently; both may fire in one cycle.
                mem_v     = (req_cnt < burst_lp);
                req_up    = mem_v && mem_ready_and_i;
                link_v    = mem_data_v_i;
                link_data = wh_flit_width_p'(mem_data_i);
                yumi      = mem_data_v_i && out_rdy;
                resp_up   = yumi;
                if (yumi && (resp_cnt == last_lp)) begin
                    rd_done = 1'b1;
                    state_d = e_wh_mem_idle;
                end
            end
            default: state_d = e_wh_mem_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= e_wh_mem_idle;
            src_cord_q <= '0;
            src_cid_q  <= '0;
            wnr_q      <= 1'b0;
            base_q     <= '0;
        end else begin
            state_q <= state_d;
            if (latch_hdr) begin
                src_cord_q <= hdr_in.src_cord;
                src_cid_q  <= hdr_in.src_cid;
                wnr_q      <= hdr_in.write_not_read;
            end
            if (latch_base)
                base_q <= mem_addr_width_p'(in_data[vcache_addr_width_p-1:0] & align_mask_lp);
        end
    end

    assign mem_v_o         = mem_v & ~reset_i;
    assign mem_data_yumi_o = yumi & ~reset_i;
    assign mem_addr_o      = req_addr;
    assign mem_data_o      = vcache_dma_data_width_p'(in_data);

`ifdef BSG_MANYCORE_VCACHE_WH_MEM_STATS_EN
    logic [31:0] stat_rd_q, stat_wr_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stat_rd_q <= '0;
            stat_wr_q <= '0;
        end else begin
            if (rd_done) stat_rd_q <= stat_rd_q + 32'd1;
            if (wr_done) stat_wr_q <= stat_wr_q + 32'd1;
        end
    end

    assign stat_rd_o = stat_rd_q;
    assign stat_wr_o = stat_wr_q;
`else
    logic unused_stat_events;
    assign unused_stat_events = rd_done ^ wr_done;
    assign stat_rd_o = 32'b0;
    assign stat_wr_o = 32'b0;
`endif

endmodule
